// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle RV32I control sequencer (BOOT/IF/ID/EX/MEM/WB/HALT)
// Optional feature macro: ILLEGAL_TRAP_EN (illegal instruction halts instead of retiring as NOP)
module mc_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        imem_ack,
    input  logic        dram_ack,
    input  logic [1:0]  flag,
    output logic        imem_req,
    output logic        dram_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npc_op,
    output logic [2:0]  sext_op,
    output logic        alub_sel,
    output logic [2:0]  alu_op,
    output logic        rf_we,
    output logic        dram_we,
    output logic [1:0]  wd_sel,
    output logic        illegal,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_BOOT, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        K_ALU_R, K_ALU_I, K_LW, K_SW, K_BR, K_JAL, K_JALR, K_LUI, K_BAD
    } kind_t;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  r_opcode;
    logic [2:0]  r_fun3;
    logic [6:0]  r_fun7;
    logic [31:0] r_instret;

    kind_t       w_kind;
    logic [2:0]  w_alu_op;
    logic [2:0]  w_sext_op;
    logic        w_alub_sel;
    logic [2:0]  w_f3_alu;
    logic        w_taken;
    logic        w_unused_inst;

    // Register/immediate fields live in the datapath's own IR copy.
    assign w_unused_inst = ^{inst[24:15], inst[11:7]};

    always_comb begin
        w_f3_alu = 3'b000;
        case (r_fun3)
            3'b000:  w_f3_alu = 3'b000;
            3'b001:  w_f3_alu = 3'b101;
            3'b100:  w_f3_alu = 3'b100;
            3'b101:  w_f3_alu = 3'b110;
            3'b110:  w_f3_alu = 3'b011;
            3'b111:  w_f3_alu = 3'b010;
            default: w_f3_alu = 3'b000;
        endcase
    end

    always_comb begin
        w_kind     = K_BAD;
        w_alu_op   = 3'b000;
        w_sext_op  = 3'b000;
        w_alub_sel = 1'b0;
        case (r_opcode)
            7'b0110011: begin
                if ((r_fun7 == 7'b0000000 && r_fun3 != 3'b010 && r_fun3 != 3'b011) ||
                    (r_fun7 == 7'b0100000 && (r_fun3 == 3'b000 || r_fun3 == 3'b101))) begin
                    w_kind = K_ALU_R;
                    if (r_fun7[5] && r_fun3 == 3'b000)
                        w_alu_op = 3'b001;
                    else if (r_fun7[5])
                        w_alu_op = 3'b111;
                    else
                        w_alu_op = w_f3_alu;
                end
            end
            7'b0010011: begin
                // fun7 is only meaningful for the shift forms; elsewhere it is immediate bits.
                if (!(r_fun3 == 3'b010 || r_fun3 == 3'b011) &&
                    !(r_fun3 == 3'b001 && r_fun7 != 7'b0000000) &&
                    !(r_fun3 == 3'b101 && r_fun7 != 7'b0000000 && r_fun7 != 7'b0100000)) begin
                    w_kind     = K_ALU_I;
                    w_alub_sel = 1'b1;
                    w_alu_op   = (r_fun3 == 3'b101 && r_fun7[5]) ? 3'b111 : w_f3_alu;
                    w_sext_op  = (r_fun3 == 3'b001 || r_fun3 == 3'b101) ? 3'b101 : 3'b000;
                end
            end
            7'b0000011: begin
                if (r_fun3 == 3'b010) begin
                    w_kind     = K_LW;
                    w_alub_sel = 1'b1;
                end
            end
            7'b0100011: begin
                if (r_fun3 == 3'b010) begin
                    w_kind     = K_SW;
                    w_alub_sel = 1'b1;
                    w_sext_op  = 3'b001;
                end
            end
            7'b1100011: begin
                if (r_fun3 == 3'b000 || r_fun3 == 3'b001 || r_fun3 == 3'b100 || r_fun3 == 3'b101) begin
                    w_kind    = K_BR;
                    w_alu_op  = 3'b001;
                    w_sext_op = 3'b010;
                end
            end
            7'b1101111: begin
                w_kind    = K_JAL;
                w_sext_op = 3'b100;
            end
            7'b1100111: begin
                if (r_fun3 == 3'b000)
                    w_kind = K_JALR;
            end
            7'b0110111: begin
                w_kind    = K_LUI;
                w_sext_op = 3'b011;
            end
            default: w_kind = K_BAD;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_fun3)
            3'b000:  w_taken = (flag == 2'b10);
            3'b001:  w_taken = !flag[1];
            3'b100:  w_taken = (flag == 2'b01);
            3'b101:  w_taken = !flag[0];
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_BOOT;
            r_opcode <= 7'd0;
            r_fun3   <= 3'd0;
            r_fun7   <= 7'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IF && imem_ack) begin
                r_opcode <= inst[6:0];
                r_fun3   <= inst[14:12];
                r_fun7   <= inst[31:25];
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        imem_req = 1'b0;
        dram_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        npc_op   = 2'b00;
        sext_op  = 3'b000;
        alub_sel = 1'b0;
        alu_op   = 3'b000;
        rf_we    = 1'b0;
        dram_we  = 1'b0;
        wd_sel   = 2'b00;
        case (r_state)
            S_BOOT: w_next = S_IF;
            S_IF: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we  = 1'b1;
                    w_next = S_ID;
                end
            end
            S_ID: begin
                sext_op  = w_sext_op;
                alub_sel = w_alub_sel;
`ifdef ILLEGAL_TRAP_EN
                w_next   = (w_kind == K_BAD) ? S_HALT : S_EX;
`else
                w_next   = S_EX;
`endif
            end
            S_EX: begin
                sext_op  = w_sext_op;
                alub_sel = w_alub_sel;
                alu_op   = w_alu_op;
                w_next   = S_IF;
                case (w_kind)
                    K_ALU_R, K_ALU_I: w_next = S_WB;
                    K_LW, K_SW:       w_next = S_MEM;
                    K_BR: begin
                        pc_we  = 1'b1;
                        npc_op = w_taken ? 2'b10 : 2'b00;
                    end
                    K_JAL: begin
                        npc_op = 2'b10;
                        wd_sel = 2'b10;
                        rf_we  = 1'b1;
                        pc_we  = 1'b1;
                    end
                    K_JALR: begin
                        npc_op = 2'b01;
                        wd_sel = 2'b10;
                        rf_we  = 1'b1;
                        pc_we  = 1'b1;
                    end
                    K_LUI: begin
                        wd_sel = 2'b11;
                        rf_we  = 1'b1;
                        pc_we  = 1'b1;
                    end
                    default: pc_we = 1'b1;
                endcase
            end
            S_MEM: begin
                sext_op  = w_sext_op;
                alub_sel = w_alub_sel;
                alu_op   = w_alu_op;
                dram_req = 1'b1;
                dram_we  = (w_kind == K_SW);
                if (dram_ack) begin
                    if (w_kind == K_SW) begin
                        pc_we  = 1'b1;
                        w_next = S_IF;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                sext_op  = w_sext_op;
                alub_sel = w_alub_sel;
                alu_op   = w_alu_op;
                rf_we    = 1'b1;
                pc_we    = 1'b1;
                wd_sel   = (w_kind == K_LW) ? 2'b01 : 2'b00;
                w_next   = S_IF;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_instret <= 32'd0;
        else if (pc_we)
            r_instret <= r_instret + 32'd1;
    end

    assign instret = r_instret;

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_illegal <= 1'b0;
        else if (r_state == S_ID && w_kind == K_BAD)
            r_illegal <= 1'b1;
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl: directed vector table, reset corners, random vs model
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic        imem_ack;
    logic        dram_ack;
    logic [1:0]  flag;
    logic        imem_req;
    logic        dram_req;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  npc_op;
    logic [2:0]  sext_op;
    logic        alub_sel;
    logic [2:0]  alu_op;
    logic        rf_we;
    logic        dram_we;
    logic [1:0]  wd_sel;
    logic        illegal;
    logic [31:0] instret;

    always #5 clk = ~clk;

    mc_ctrl u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inst     (inst),
        .imem_ack (imem_ack),
        .dram_ack (dram_ack),
        .flag     (flag),
        .imem_req (imem_req),
        .dram_req (dram_req),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .npc_op   (npc_op),
        .sext_op  (sext_op),
        .alub_sel (alub_sel),
        .alu_op   (alu_op),
        .rf_we    (rf_we),
        .dram_we  (dram_we),
        .wd_sel   (wd_sel),
        .illegal  (illegal),
        .instret  (instret)
    );

    // Expected per-instruction behaviour; -1 marks a field that does not apply.
    typedef struct {
        logic [31:0] ins;
        logic [1:0]  fl;
        int iw;
        int dw;
        int cyc;
        int rf;
        int wd;
        int aop;
        int npc;
        int dcyc;
        int dwe;
    } vec_t;

    typedef struct {
        int done;
        int start_req;
        int cycles;
        int icyc;
        int dcyc;
        int ir;
        int rf;
        int wd;
        int aop;
        int npc;
        int dwe;
        int bad_we;
        int instret0;
    } res_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] m_instret = 32'd0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // 0 illegal, 1 R-ALU, 2 I-ALU, 3 lw, 4 sw, 5 branch, 6 jal, 7 jalr, 8 lui
    function automatic int kind_of(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h33: return ((f7 == 7'h00 && f3 != 3'd2 && f3 != 3'd3) ||
                           (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? 1 : 0;
            7'h13: begin
                if (f3 == 3'd2 || f3 == 3'd3) return 0;
                if (f3 == 3'd1) return (f7 == 7'h00) ? 2 : 0;
                if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? 2 : 0;
                return 2;
            end
            7'h03: return (f3 == 3'd2) ? 3 : 0;
            7'h23: return (f3 == 3'd2) ? 4 : 0;
            7'h63: return (f3 inside {3'd0, 3'd1, 3'd4, 3'd5}) ? 5 : 0;
            7'h6F: return 6;
            7'h67: return (f3 == 3'd0) ? 7 : 0;
            7'h37: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic vec_t model(input logic [31:0] ins, input logic [1:0] fl, input int iw, input int dw);
        vec_t e;
        int   k;
        int   base[9] = '{3, 4, 4, 5, 4, 3, 3, 3, 3};
        logic [2:0] f3;
        bit   taken;
        k  = kind_of(ins);
        f3 = ins[14:12];
        e.ins = ins; e.fl = fl; e.iw = iw; e.dw = dw;
        e.cyc  = iw + base[k] + ((k == 3 || k == 4) ? dw : 0);
        e.rf   = (k inside {1, 2, 3, 6, 7, 8}) ? 1 : 0;
        e.wd   = -1;
        if (e.rf == 1)
            e.wd = (k == 3) ? 1 : (k == 6 || k == 7) ? 2 : (k == 8) ? 3 : 0;
        e.aop  = -1;
        if (k == 1 || k == 2) begin
            case (f3)
                3'd0: e.aop = (k == 1 && ins[30]) ? 1 : 0;
                3'd1: e.aop = 5;
                3'd4: e.aop = 4;
                3'd5: e.aop = ins[30] ? 7 : 6;
                3'd6: e.aop = 3;
                default: e.aop = 2;
            endcase
        end
        taken = (f3 == 3'd0) ? (fl == 2'b10) : (f3 == 3'd1) ? !fl[1] :
                (f3 == 3'd4) ? (fl == 2'b01) : !fl[0];
        e.npc  = (k == 5) ? (taken ? 2 : 0) : (k == 6) ? 2 : (k == 7) ? 1 : 0;
        e.dcyc = (k == 3 || k == 4) ? dw + 1 : 0;
        e.dwe  = (k == 4) ? 1 : 0;
        return e;
    endfunction

    // Runs one instruction from its first IF cycle until pc_we (or a cycle budget).
    task automatic run_instr(input logic [31:0] ins, input logic [1:0] fl, input int iw,
                             input int dw, input bit noise, output res_t r);
        int ireq;
        int dreq;
        r = '{default: 0};
        ireq = 0;
        dreq = 0;
        for (int c = 0; c < 64 && r.done == 0; c++) begin
            @(negedge clk);
            inst = ins;
            flag = fl;
            imem_ack = 1'b0;
            dram_ack = 1'b0;
            #1;
            if (imem_req) begin
                imem_ack = (ireq == iw);
                ireq++;
            end else if (noise) begin
                imem_ack = 1'($urandom_range(0, 1));
            end
            if (dram_req) begin
                dram_ack = (dreq == dw);
                dreq++;
            end else if (noise) begin
                dram_ack = 1'($urandom_range(0, 1));
            end
            #1;
            if (c == 0) begin
                r.start_req = int'(imem_req);
                r.instret0  = int'(instret);
            end
            r.cycles++;
            r.icyc += int'(imem_req);
            r.dcyc += int'(dram_req);
            r.ir   += int'(ir_we);
            r.rf   += int'(rf_we);
            if (rf_we) begin
                r.wd  = int'(wd_sel);
                r.aop = int'(alu_op);
            end
            if (dram_req && dram_we) r.dwe = 1;
            if (dram_we && !dram_req) r.bad_we = 1;
            if (pc_we) begin
                r.npc  = int'(npc_op);
                r.done = 1;
            end
        end
    endtask

    task automatic check_run(input string tag, input vec_t e, input res_t r);
        chk({tag, ".done"}, r.done, 1);
        chk({tag, ".imem_req_first"}, r.start_req, 1);
        chk({tag, ".instret_start"}, r.instret0, int'(m_instret));
        chk({tag, ".cycles"}, r.cycles, e.cyc);
        chk({tag, ".imem_req_cycles"}, r.icyc, e.iw + 1);
        chk({tag, ".ir_we_count"}, r.ir, 1);
        chk({tag, ".rf_we_count"}, r.rf, e.rf);
        if (e.wd >= 0) chk({tag, ".wd_sel"}, r.wd, e.wd);
        if (e.aop >= 0) chk({tag, ".alu_op"}, r.aop, e.aop);
        chk({tag, ".npc_op"}, r.npc, e.npc);
        chk({tag, ".dram_req_cycles"}, r.dcyc, e.dcyc);
        chk({tag, ".dram_we"}, r.dwe, e.dwe);
        chk({tag, ".dram_we_unqualified"}, r.bad_we, 0);
    endtask

    function automatic int all_outs();
        return int'({imem_req, dram_req, ir_we, pc_we, npc_op, sext_op, alub_sel,
                     alu_op, rf_we, dram_we, wd_sel, illegal});
    endfunction

    vec_t vt[$];
    vec_t e;
    res_t r;
    logic [31:0] rins;
    logic [6:0]  ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h7F};
    bit          seen;

    initial begin
        //            ins            fl     iw dw cyc rf wd aop npc dcyc dwe
        vt.push_back('{32'h002081B3, 2'b00, 0, 0, 4, 1, 0, 0, 0, 0, 0});
        vt.push_back('{32'h00802283, 2'b00, 0, 3, 8, 1, 1, -1, 0, 4, 0});
        vt.push_back('{32'h00208463, 2'b10, 0, 0, 3, 0, -1, -1, 2, 0, 0});
        vt.push_back('{32'h00208463, 2'b00, 0, 0, 3, 0, -1, -1, 0, 0, 0});
        vt.push_back('{32'h0050A223, 2'b00, 0, 0, 4, 0, -1, -1, 0, 1, 1});
        vt.push_back('{32'h402081B3, 2'b00, 2, 0, 6, 1, 0, 1, 0, 0, 0});
        vt.push_back('{32'h4020D1B3, 2'b00, 0, 0, 4, 1, 0, 7, 0, 0, 0});
        vt.push_back('{32'h0020D193, 2'b00, 0, 0, 4, 1, 0, 6, 0, 0, 0});
        vt.push_back('{32'h0050F193, 2'b00, 0, 0, 4, 1, 0, 2, 0, 0, 0});
        vt.push_back('{32'h0020C1B3, 2'b00, 0, 0, 4, 1, 0, 4, 0, 0, 0});
        vt.push_back('{32'h0020E1B3, 2'b00, 0, 0, 4, 1, 0, 3, 0, 0, 0});
        vt.push_back('{32'h002091B3, 2'b00, 0, 0, 4, 1, 0, 5, 0, 0, 0});
        vt.push_back('{32'h00209463, 2'b00, 0, 0, 3, 0, -1, -1, 2, 0, 0});
        vt.push_back('{32'h00209463, 2'b10, 0, 0, 3, 0, -1, -1, 0, 0, 0});
        vt.push_back('{32'h0020C463, 2'b01, 0, 0, 3, 0, -1, -1, 2, 0, 0});
        vt.push_back('{32'h0020C463, 2'b00, 0, 0, 3, 0, -1, -1, 0, 0, 0});
        vt.push_back('{32'h0020D463, 2'b00, 0, 0, 3, 0, -1, -1, 2, 0, 0});
        vt.push_back('{32'h0020D463, 2'b01, 0, 0, 3, 0, -1, -1, 0, 0, 0});
        vt.push_back('{32'h010000EF, 2'b00, 0, 0, 3, 1, 2, -1, 2, 0, 0});
        vt.push_back('{32'h000100E7, 2'b00, 0, 0, 3, 1, 2, -1, 1, 0, 0});
        vt.push_back('{32'h123453B7, 2'b00, 1, 0, 4, 1, 3, -1, 0, 0, 0});
        vt.push_back('{32'h0050A223, 2'b00, 1, 2, 7, 0, -1, -1, 0, 3, 1});
        vt.push_back('{32'h00802283, 2'b00, 1, 0, 6, 1, 1, -1, 0, 1, 0});

        rst_n = 1'b0;
        inst = 32'd0;
        imem_ack = 1'b0;
        dram_ack = 1'b0;
        flag = 2'b00;
        repeat (3) @(negedge clk);
        imem_ack = 1'b1;
        dram_ack = 1'b1;
        #1;
        chk("reset.outputs", all_outs(), 0);
        chk("reset.instret", int'(instret), 0);
        imem_ack = 1'b0;
        dram_ack = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("boot.imem_req", int'(imem_req), 0);

        foreach (vt[i]) begin
            run_instr(vt[i].ins, vt[i].fl, vt[i].iw, vt[i].dw, 1'b0, r);
            check_run($sformatf("vec%0d", i), vt[i], r);
            m_instret++;
        end

`ifdef ILLEGAL_TRAP_EN
        run_instr(32'hFFFFFFFF, 2'b00, 0, 0, 1'b0, r);
        chk("trap.no_retire", r.done, 0);
        chk("trap.imem_req_cycles", r.icyc, 1);
        chk("trap.illegal", int'(illegal), 1);
        chk("trap.imem_req_after", int'(imem_req), 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("trap.reset_clears", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_instret = 32'd0;
`else
        e = model(32'hFFFFFFFF, 2'b00, 0, 0);
        run_instr(32'hFFFFFFFF, 2'b00, 0, 0, 1'b0, r);
        check_run("nop_ffff", e, r);
        m_instret++;
        chk("nop_ffff.illegal", int'(illegal), 0);
        e = model(32'h0020A1B3, 2'b00, 1, 0);
        run_instr(32'h0020A1B3, 2'b00, 1, 0, 1'b0, r);
        check_run("nop_slt", e, r);
        m_instret++;
`endif

        // Reset asserted while a sw sits in MEM waiting for its ack.
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            inst = 32'h0050A223;
            imem_ack = 1'b0;
            dram_ack = 1'b0;
            #1;
            if (imem_req) imem_ack = 1'b1;
            if (dram_req) seen = 1'b1;
        end
        chk("rstmem.reached_mem", int'(seen), 1);
        chk("rstmem.dram_we_before", int'(dram_we), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmem.dram_req", int'(dram_req), 0);
        chk("rstmem.dram_we", int'(dram_we), 0);
        chk("rstmem.strobes", int'({rf_we, pc_we, ir_we}), 0);
        @(negedge clk);
        chk("rstmem.instret", int'(instret), 0);
        rst_n = 1'b1;
        #1;
        chk("rstmem.boot", int'(imem_req), 0);
        m_instret = 32'd0;

        for (int k = 0; k < 200; k++) begin
            int iw;
            int dw;
            logic [1:0] fl;
            rins = $urandom;
            rins[6:0] = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 1) == 1)
                rins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
`ifdef ILLEGAL_TRAP_EN
            if (kind_of(rins) == 0) rins = 32'h123453B7;
`endif
            fl = 2'($urandom_range(0, 3));
            iw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            e = model(rins, fl, iw, dw);
            run_instr(rins, fl, iw, dw, 1'b1, r);
            check_run($sformatf("rnd%0d_%08h", k, rins), e, r);
            m_instret++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
